// File: rtl/wave_sequencer.sv
// wave_sequencer: autonomous playlist controller for the waveform-generator datapath.
// A small program table holds {freq, wave, amp, dwell} entries. On start the sequencer
// steps through entries 0..last_idx, pulsing ld and presenting parIn/mux_sel/Amp_Sel to
// the datapath, holding each entry for max(dwell,1)*PRESCALE cycles.
// Optional feature macro: WAVE_SEQ_LOOP_EN -- when defined the playlist wraps to entry 0
// forever (until stop or reset) and done is never pulsed; when undefined the playlist runs
// once, pulses done and returns to idle holding the last entry's outputs.

module wave_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DWELL_W  = 16,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [4:0]                 prog_freq,
  input  logic [2:0]                 prog_wave,
  input  logic [1:0]                 prog_amp,
  input  logic [DWELL_W-1:0]         prog_dwell,
  input  logic [$clog2(DEPTH)-1:0]   last_idx,
  input  logic                       start,
  input  logic                       stop,
  output logic                       ld,
  output logic [4:0]                 parIn,
  output logic [2:0]                 mux_sel,
  output logic [1:0]                 Amp_Sel,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   cur_idx
);

  localparam int unsigned IW = $clog2(DEPTH);
  // Wide enough for (2^DWELL_W - 1) * PRESCALE - 1 without overflow.
  localparam int unsigned CW = DWELL_W + $clog2(PRESCALE);
  localparam logic [CW-1:0] PrescaleW = CW'(PRESCALE);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDwell,
    StFinish
  } state_e;

  // Program table (not cleared by reset).
  logic [4:0]         freq_tbl  [DEPTH];
  logic [2:0]         wave_tbl  [DEPTH];
  logic [1:0]         amp_tbl   [DEPTH];
  logic [DWELL_W-1:0] dwell_tbl [DEPTH];

  state_e        state_q, state_d;
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    par_q;
  logic [2:0]    mux_q;
  logic [1:0]    amp_q;

  logic               enter_load;
  logic [2:0]         wave_rd;
  logic [2:0]         wave_safe;
  logic [DWELL_W-1:0] dwell_rd;
  logic [CW-1:0]      dwell_eff;
  logic [CW-1:0]      cnt_load;

  // Table write port: usable in any state, including mid-sequence.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      freq_tbl[prog_addr]  <= prog_freq;
      wave_tbl[prog_addr]  <= prog_wave;
      amp_tbl[prog_addr]   <= prog_amp;
      dwell_tbl[prog_addr] <= prog_dwell;
    end
  end

  // Entry decode: sanitise waveform of the entry about to load, size the dwell of the
  // entry currently in LOAD.
  always_comb begin
    wave_rd   = wave_tbl[cur_idx_d];
    wave_safe = (wave_rd > 3'd5) ? 3'd0 : wave_rd;
    dwell_rd  = dwell_tbl[cur_idx_q];
    dwell_eff = (dwell_rd == '0) ? CW'(1) : CW'(dwell_rd);
    cnt_load  = (dwell_eff * PrescaleW) - CW'(1);
  end

  // Next-state logic for the playlist FSM, index, latched last index and dwell counter.
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    enter_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d    = StLoad;
          cur_idx_d  = '0;
          last_d     = last_idx;
          enter_load = 1'b1;
        end
      end
      StLoad: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_load;
          state_d = StDwell;
        end
      end
      StDwell: begin
        if (stop) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          if (cur_idx_q != last_q) begin
            cur_idx_d  = cur_idx_q + 1'b1;
            state_d    = StLoad;
            enter_load = 1'b1;
          end else begin
            state_d = StFinish;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFinish: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
`ifdef WAVE_SEQ_LOOP_EN
          // Wrap: pick up a possibly new last_idx for the next pass.
          last_d     = last_idx;
          cur_idx_d  = '0;
          state_d    = StLoad;
          enter_load = 1'b1;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, index and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cur_idx_q <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Datapath controls are captured on the edge into LOAD and held otherwise, so a
  // stopped sequence keeps playing the last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= '0;
      mux_q <= '0;
      amp_q <= '0;
    end else if (enter_load) begin
      par_q <= freq_tbl[cur_idx_d];
      mux_q <= wave_safe;
      amp_q <= amp_tbl[cur_idx_d];
    end
  end

  // Output strobes; a stop in the same cycle suppresses ld/done.
  always_comb begin
    ld      = (state_q == StLoad) && !stop;
`ifdef WAVE_SEQ_LOOP_EN
    done    = 1'b0;
`else
    done    = (state_q == StFinish) && !stop;
`endif
    busy    = (state_q != StIdle);
    parIn   = par_q;
    mux_sel = mux_q;
    Amp_Sel = amp_q;
    cur_idx = cur_idx_q;
  end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

- Autonomous playlist controller for the waveform-generator datapath.
- Holds a small program table of entries (frequency code, waveform select, amplitude select, dwell time).
- On `start`, steps through entries 0..`last_idx`, driving the datapath's `ld`/`parIn`, `mux_sel` and `Amp_Sel` controls.
- Sits between the board-level switch/button logic and the datapath; shares the datapath's `clk` and `reset`.

## Interface

Parameters:
- `DEPTH`, 8, number of program entries; power of two; index width `IW = log2(DEPTH)`.
- `DWELL_W`, 16, width of each entry's dwell field.
- `PRESCALE`, 50000, clk cycles per dwell unit; ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program-table write strobe.
- `prog_addr`  in  IW  table entry to write.
- `prog_freq`  in  5  frequency code to store.
- `prog_wave`  in  3  waveform select to store.
- `prog_amp`  in  2  amplitude select to store.
- `prog_dwell`  in  DWELL_W  dwell count to store, in units of `PRESCALE` cycles.
- `last_idx`  in  IW  index of the final entry in the sequence; sampled at start and at each wrap.
- `start`  in  1  begin the sequence from entry 0; level or pulse.
- `stop`  in  1  abort the sequence.
- `ld`  out  1  one-cycle load strobe to the frequency selector.
- `parIn`  out  5  frequency code to the frequency selector.
- `mux_sel`  out  3  waveform select, 0..5.
- `Amp_Sel`  out  2  amplitude select.
- `busy`  out  1  high while the sequence is running.
- `done`  out  1  one-cycle pulse when a non-looping sequence completes.
- `cur_idx`  out  IW  entry currently applied.

## Operation

- Program table: `DEPTH` × (5+3+2+`DWELL_W`) registers.
  - Written synchronously when `prog_we`=1, in any state.
  - An entry is read only at its LOAD cycle, so a write to an entry not yet loaded takes effect this pass.
  - Table contents are not cleared by `reset`.
- FSM states: IDLE, LOAD, DWELL, FINISH.
  - IDLE: `busy`=0. On `start`=1 and `stop`=0 → LOAD; `cur_idx`←0; latch `last_idx`.
  - LOAD (1 cycle):
    - `ld`=1.
    - `parIn`, `mux_sel`, `Amp_Sel` are registered from entry `cur_idx` on entry to this cycle and are valid in the same cycle as `ld`.
    - Load dwell counter with max(dwell,1)×`PRESCALE`−1. Dwell 0 is treated as 1.
    - → DWELL.
  - DWELL: decrement counter each cycle. At 0:
    - If `cur_idx` ≠ latched last: `cur_idx`+1 → LOAD.
    - Else → FINISH.
  - FINISH (1 cycle):
    - Without the loop feature: `done`=1 → IDLE.
    - With the loop feature: re-latch `last_idx`, `cur_idx`←0 → LOAD; `done` stays 0.
- Stored `prog_wave` values 6 or 7 are illegal and are output as `mux_sel`=0.
- `stop`=1 in LOAD/DWELL/FINISH → IDLE next cycle.
  - `ld`/`done` are not asserted in that cycle.
  - `parIn`/`mux_sel`/`Amp_Sel`/`cur_idx` hold their last values, so the output keeps playing the last waveform.
- `start` while busy: ignored. `start`+`stop` in the same cycle: `stop` wins.
- A latched `last_idx` ≥ `DEPTH` cannot occur (width-limited).

## Timing

- Reset values: `ld`=0, `parIn`=0, `mux_sel`=0, `Amp_Sel`=0, `busy`=0, `done`=0, `cur_idx`=0, state IDLE, dwell counter 0.
- Reset mid-sequence: everything above applies on the next edge; the table is kept.
- Start latency: `start` sampled at edge N → `ld`=1 and entry-0 outputs valid in cycle N+1; `busy`=1 from cycle N+1.
- Entry period (`ld` to next `ld`): 1 + max(dwell,1)×`PRESCALE` cycles.
- Non-loop end: FINISH cycle follows the last DWELL cycle.
  - `done`=1 at LOAD_last + max(dwell,1)×`PRESCALE` + 1.
  - `busy` falls the cycle after `done`.
- Loop wrap: `ld` for entry 0 is 1 cycle after FINISH, so the last entry's period is 2 + dwell×`PRESCALE`.
- `busy`=1 in LOAD, DWELL and FINISH.
- Dwell counter width: `DWELL_W` + ceil(log2(`PRESCALE`)) bits; no overflow at maximum dwell.

## Configuration

- `WAVE_SEQ_LOOP_EN`
  - Defined: after FINISH the sequence wraps to entry 0 indefinitely until `stop` or `reset`; `done` is never asserted.
  - Undefined: the sequence runs once, pulses `done` in FINISH, then returns to IDLE holding the last entry's outputs.

## Test plan

Bench uses `PRESCALE`=4, `DEPTH`=8.

- Reset → all outputs 0, `busy`=0. Program entry0 = {freq 5'd3, wave 3, amp 2, dwell 2}; `last_idx`=0; pulse `start` at edge N:
  - `ld`=1, `parIn`=3, `mux_sel`=3, `Amp_Sel`=2 at N+1.
  - Without loop: `done`=1 at N+10, then IDLE.
- Entries 0..2 with dwell 1, 0, 3; `last_idx`=2 → `ld` pulses at N+1, N+6, N+11; `done` at N+24.
- Entry wave 3'd7 → `mux_sel`=0 during that entry.
- `stop` mid-DWELL of entry 1 → `busy`=0 next cycle, no further `ld`, `mux_sel` holds entry-1 value. `start`+`stop` together in IDLE → stays IDLE.
- With `WAVE_SEQ_LOOP_EN`, 2 entries of dwell 1:
  - `ld` at N+1, N+6, N+12, N+17, …
  - `cur_idx` toggles 0,1,0,1; `done` never asserted.
- Rewrite entry 1 via `prog_we` during entry-0 DWELL → the new values appear at the entry-1 `ld`. `reset` asserted mid-DWELL → reset values next cycle; a restart replays the unchanged table.
